word_assembler: RTL

Receive-side counterpart to the transmit byte selector: collects four consecutive bytes from the UART receiver and assembles them MSB-first into one 32-bit word for the ALU operand path. It sits between the UART RX byte stream and the ALU command/operand logic. It uses valid/ready handshakes on both sides, and an optional inter-byte timeout discards partial words after a line stall.

---
 rtl/word_assembler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/word_assembler.sv
// Assembles four consecutive UART RX bytes MSB-first into a 32-bit word with valid/ready on both sides.
// Optional inter-byte timeout compiled in with WORD_ASSEMBLER_TIMEOUT_EN.
module word_assembler #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [2:0]  byte_count_o,
  output logic        timeout_o
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  count_q, count_d;
  logic        accept;

  assign accept = (state_q == COLLECT) && byte_valid_i;

`ifdef WORD_ASSEMBLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
    tmr_d     = tmr_q;
    timeout_d = 1'b0;
`endif
    // clear wins over everything, including a byte presented the same cycle
    if (clear_i) begin
      state_d = COLLECT;
      count_d = 3'd0;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
      tmr_d   = '0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            shift_d = {shift_q[23:0], byte_i};
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) state_d = HOLD;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
            tmr_d = '0;
          end else if (count_q != 3'd0) begin
            if (tmr_q == TMAX) begin
              count_d   = 3'd0;
              tmr_d     = '0;
              timeout_d = 1'b1;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end else begin
            tmr_d = '0;
`endif
          end
        end
        HOLD: begin
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
          tmr_d = '0;
`endif
          // shift register keeps stale data; next bytes overwrite it
          if (word_ready_i) begin
            state_d = COLLECT;
            count_d = 3'd0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      shift_q <= 32'h0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

`ifdef WORD_ASSEMBLER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign byte_ready_o = (state_q == COLLECT);
  assign word_valid_o = (state_q == HOLD);
  assign word_o       = shift_q;
  assign byte_count_o = count_q;

endmodule
